// File: rtl/fizzbuzz_pkg.sv
// Shared types for the FizzBuzz stream sequencer.
// Beat classification and sequencer FSM states.
package fizzbuzz_pkg;

  typedef enum logic [1:0] {
    NUM      = 2'd0,
    FIZZ     = 2'd1,
    BUZZ     = 2'd2,
    FIZZBUZZ = 2'd3
  } kind_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up-counter with synchronous clear.
// wrap flags the increment that rolls MOD-1 back to 0.
module mod_counter #(
  parameter int MOD = 3,
  parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  assign wrap = inc & (value == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (clr || wrap) begin
      value <= '0;
    end else if (inc) begin
      value <= value + W'(1);
    end
  end

endmodule

// File: rtl/fizzbuzz_stream_ctrl.sv
// FizzBuzz stream sequencer: emits cfg_len classified beats
// over a valid/ready handshake, with abort and done pulse.
module fizzbuzz_stream_ctrl
  import fizzbuzz_pkg::*;
#(
  parameter int FIZZ_DIV   = 3,
  parameter int BUZZ_DIV   = 5,
  parameter int MAX_CYCLES = 100,
  parameter int LW         = 16,
  parameter int VW         = $clog2(MAX_CYCLES)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          stop,
  input  logic [LW-1:0] cfg_len,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [VW-1:0] out_value,
  output logic [1:0]    out_kind,
  output logic          busy,
  output logic          done
);

  localparam int FW = $clog2(FIZZ_DIV);
  localparam int BW = $clog2(BUZZ_DIV);

  state_t        state;
  logic [LW-1:0] remaining;
  logic          hs;
  logic          ld;
  logic          cnt_wrap;
  logic          res_clr;
  logic [FW-1:0] fz_res;
  logic [BW-1:0] bz_res;
  logic          fz_wrap_unused;
  logic          bz_wrap_unused;
  kind_t         kind;

  assign hs      = out_valid & out_ready;
  assign ld      = (state == IDLE) & start;
  // residues restart with the value counter so they track it exactly
  assign res_clr = ld | cnt_wrap;

  mod_counter #(.MOD(MAX_CYCLES), .W(VW)) u_val (
    .clk   (clk),
    .reset (reset),
    .clr   (ld),
    .inc   (hs),
    .value (out_value),
    .wrap  (cnt_wrap)
  );

  mod_counter #(.MOD(FIZZ_DIV), .W(FW)) u_fizz (
    .clk   (clk),
    .reset (reset),
    .clr   (res_clr),
    .inc   (hs),
    .value (fz_res),
    .wrap  (fz_wrap_unused)
  );

  mod_counter #(.MOD(BUZZ_DIV), .W(BW)) u_buzz (
    .clk   (clk),
    .reset (reset),
    .clr   (res_clr),
    .inc   (hs),
    .value (bz_res),
    .wrap  (bz_wrap_unused)
  );

  assign kind     = kind_t'({bz_res == '0, fz_res == '0});
  assign out_kind = kind;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            if (cfg_len != '0) begin
              state     <= RUN;
              remaining <= cfg_len;
              out_valid <= 1'b1;
              busy      <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (hs) begin
            remaining <= remaining - LW'(1);
          end
          if (stop || (hs && remaining == LW'(1))) begin
            state     <= DONE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
        end
      endcase
    end
  end

endmodule
